lowx_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single lowX memory port between the instruction-side align buffer refill path and the data-side cache/uncached path. It sits between `gray_align_buffer` / data cache and the memory interface. It grants one outstanding transaction at a time with round-robin fairness, holds the request stable toward memory, and steers the response back to the owner combinationally.

---
 rtl/lowx_mem_arbiter_pkg.sv | 16 +
 rtl/lowx_mem_arbiter_if.sv | 47 ++++
 rtl/lowx_rr_arb2.sv | 22 ++
 rtl/lowx_mem_arbiter.sv | 119 +++++++++++
 tb/tb_lowx_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lowx_mem_arbiter_pkg.sv
// Shared types for the lowX memory-port arbiter: FSM state and transaction owner.
package lowx_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } lowx_arb_state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } lowx_owner_e;

endpackage

// File: rtl/lowx_mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the lowX memory port.
// The master modport is the arbiter's view; slave is the surrounding environment.
interface lowx_mem_arbiter_if #(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
);
  logic                ireq_valid_i;
  logic [XLEN-1:0]     ireq_addr_i;
  logic                ireq_uncached_i;
  logic                ires_valid_o;
  logic [BLK_SIZE-1:0] ires_data_o;

  logic                dreq_valid_i;
  logic [XLEN-1:0]     dreq_addr_i;
  logic                dreq_we_i;
  logic [BLK_SIZE-1:0] dreq_wdata_i;
  logic                dreq_uncached_i;
  logic                dres_valid_o;
  logic [BLK_SIZE-1:0] dres_data_o;

  logic                mreq_valid_o;
  logic [XLEN-1:0]     mreq_addr_o;
  logic                mreq_we_o;
  logic [BLK_SIZE-1:0] mreq_wdata_o;
  logic                mreq_uncached_o;
  logic                mreq_ready_i;
  logic                mres_valid_i;
  logic [BLK_SIZE-1:0] mres_data_i;

  modport master (
    input  ireq_valid_i, ireq_addr_i, ireq_uncached_i,
    output ires_valid_o, ires_data_o,
    input  dreq_valid_i, dreq_addr_i, dreq_we_i, dreq_wdata_i, dreq_uncached_i,
    output dres_valid_o, dres_data_o,
    output mreq_valid_o, mreq_addr_o, mreq_we_o, mreq_wdata_o, mreq_uncached_o,
    input  mreq_ready_i, mres_valid_i, mres_data_i
  );

  modport slave (
    output ireq_valid_i, ireq_addr_i, ireq_uncached_i,
    input  ires_valid_o, ires_data_o,
    output dreq_valid_i, dreq_addr_i, dreq_we_i, dreq_wdata_i, dreq_uncached_i,
    input  dres_valid_o, dres_data_o,
    input  mreq_valid_o, mreq_addr_o, mreq_we_o, mreq_wdata_o, mreq_uncached_o,
    output mreq_ready_i, mres_valid_i, mres_data_i
  );
endinterface

// File: rtl/lowx_rr_arb2.sv
// Combinational two-way round-robin pick between instruction and data requests.
module lowx_rr_arb2
  import lowx_mem_arbiter_pkg::*;
(
  input  logic        ireq_valid,
  input  logic        dreq_valid,
  input  lowx_owner_e last_grant,
  output logic        grant,
  output lowx_owner_e owner
);

  always_comb begin
    grant = ireq_valid | dreq_valid;
    owner = OWN_I;
    if (ireq_valid && dreq_valid) begin
      owner = (last_grant == OWN_I) ? OWN_D : OWN_I;
    end else if (dreq_valid) begin
      owner = OWN_D;
    end
  end

endmodule

// File: rtl/lowx_mem_arbiter.sv
// Shares the lowX memory port between the instruction refill and data paths,
// one outstanding transaction at a time, response steered back combinationally.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no transaction; grant and latch the next request
// ST_REQ     | latched request presented to memory until mreq_ready_i
// ST_WAIT    | accepted; forward mres to the owner when mres_valid_i
// ST_RELEASE | dead cycle so the owner can drop its level request
module lowx_mem_arbiter
  import lowx_mem_arbiter_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int BLK_SIZE = 128
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  lowx_mem_arbiter_if.master bus
);

  localparam int              BOFFSET   = $clog2(BLK_SIZE / 8);
  localparam logic [XLEN-1:0] LINE_MASK = {XLEN{1'b1}} << BOFFSET;

  lowx_arb_state_e     state_q, state_d;
  lowx_owner_e         last_grant_q, last_grant_d;
  lowx_owner_e         owner_q, owner_d;
  logic [XLEN-1:0]     addr_q, addr_d;
  logic                we_q, we_d;
  logic [BLK_SIZE-1:0] wdata_q, wdata_d;
  logic                uncached_q, uncached_d;

  logic                grant;
  lowx_owner_e         arb_owner;
  logic                rsp_fire;

  lowx_rr_arb2 u_rr_arb2 (
    .ireq_valid (bus.ireq_valid_i),
    .dreq_valid (bus.dreq_valid_i),
    .last_grant (last_grant_q),
    .grant      (grant),
    .owner      (arb_owner)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      last_grant_q <= OWN_D;
      owner_q      <= OWN_I;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      uncached_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      uncached_q   <= uncached_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    uncached_d   = uncached_q;
    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d      = ST_REQ;
          owner_d      = arb_owner;
          last_grant_d = arb_owner;
          // Cached accesses are line-aligned; uncached keep the byte address.
          if (arb_owner == OWN_I) begin
            addr_d     = bus.ireq_uncached_i ? bus.ireq_addr_i : (bus.ireq_addr_i & LINE_MASK);
            we_d       = 1'b0;
            wdata_d    = '0;
            uncached_d = bus.ireq_uncached_i;
          end else begin
            addr_d     = bus.dreq_uncached_i ? bus.dreq_addr_i : (bus.dreq_addr_i & LINE_MASK);
            we_d       = bus.dreq_we_i;
            wdata_d    = bus.dreq_wdata_i;
            uncached_d = bus.dreq_uncached_i;
          end
        end
      end
      ST_REQ: begin
        if (bus.mreq_ready_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.mres_valid_i) state_d = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.mreq_valid_o    = (state_q == ST_REQ);
  assign bus.mreq_addr_o     = addr_q;
  assign bus.mreq_we_o       = we_q;
  assign bus.mreq_wdata_o    = wdata_q;
  assign bus.mreq_uncached_o = uncached_q;

  assign rsp_fire         = (state_q == ST_WAIT) && bus.mres_valid_i;
  assign bus.ires_valid_o = rsp_fire && (owner_q == OWN_I);
  assign bus.dres_valid_o = rsp_fire && (owner_q == OWN_D);
  assign bus.ires_data_o  = bus.ires_valid_o ? bus.mres_data_i : '0;
  assign bus.dres_data_o  = bus.dres_valid_o ? bus.mres_data_i : '0;

endmodule

// File: tb/tb_lowx_mem_arbiter.sv
// Self-checking bench for lowx_mem_arbiter: directed scenarios with literal
// expectations plus a randomized run compared every cycle against a transaction model.
module tb_lowx_mem_arbiter;
  localparam int XLEN = 32;
  localparam int BLK  = 128;

  logic clk_i = 1'b0;
  logic rst_n = 1'b0;

  lowx_mem_arbiter_if #(.XLEN(XLEN), .BLK_SIZE(BLK)) bus ();

  lowx_mem_arbiter #(.XLEN(XLEN), .BLK_SIZE(BLK)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending transaction, whether memory took it,
  // and a one-cycle cool-down after its response.
  bit             m_busy, m_acc, m_cool, m_last, m_own;  // owner bit: 0 = I, 1 = D
  logic [31:0]    m_addr;
  logic           m_we, m_unc;
  logic [127:0]   m_wdata;
  bit             seen_i, seen_d;

  function automatic logic [31:0] expect_addr(input logic [31:0] a, input logic unc);
    return unc ? a : (a - (a % 32'd16));
  endfunction

  task automatic mdl_reset();
    m_busy = 0; m_acc = 0; m_cool = 0; m_last = 1; m_own = 0;
    m_addr = '0; m_we = 0; m_unc = 0; m_wdata = '0;
  endtask

  task automatic mdl_step();
    bit iv, dv;
    iv = bus.ireq_valid_i;
    dv = bus.dreq_valid_i;
    if (m_cool) begin
      m_cool = 0;
    end else if (m_busy && !m_acc) begin
      if (bus.mreq_ready_i) m_acc = 1;
    end else if (m_busy) begin
      if (bus.mres_valid_i) begin
        m_busy = 0;
        m_cool = 1;
      end
    end else if (iv || dv) begin
      m_own  = (iv && dv) ? !m_last : dv;
      m_last = m_own;
      m_busy = 1;
      m_acc  = 0;
      if (m_own == 0) begin
        m_addr = expect_addr(bus.ireq_addr_i, bus.ireq_uncached_i);
        m_we = 0; m_wdata = '0; m_unc = bus.ireq_uncached_i;
      end else begin
        m_addr = expect_addr(bus.dreq_addr_i, bus.dreq_uncached_i);
        m_we = bus.dreq_we_i; m_wdata = bus.dreq_wdata_i; m_unc = bus.dreq_uncached_i;
      end
    end
  endtask

  always @(posedge clk_i) begin
    if (!rst_n) mdl_reset();
    else        mdl_step();
  end

  always @(negedge rst_n) mdl_reset();

  always @(negedge clk_i) begin
    bit e_mv, e_rsp, e_i, e_d;
    e_mv  = m_busy && !m_acc;
    e_rsp = m_busy && m_acc && (bus.mres_valid_i === 1'b1);
    e_i   = e_rsp && (m_own == 0);
    e_d   = e_rsp && (m_own == 1);
    chk("mdl_mreq_valid", 128'(bus.mreq_valid_o), 128'(e_mv));
    if (e_mv) begin
      chk("mdl_mreq_addr", 128'(bus.mreq_addr_o), 128'(m_addr));
      chk("mdl_mreq_we", 128'(bus.mreq_we_o), 128'(m_we));
      chk("mdl_mreq_wdata", bus.mreq_wdata_o, m_wdata);
      chk("mdl_mreq_unc", 128'(bus.mreq_uncached_o), 128'(m_unc));
    end
    chk("mdl_ires_valid", 128'(bus.ires_valid_o), 128'(e_i));
    chk("mdl_dres_valid", 128'(bus.dres_valid_o), 128'(e_d));
    chk("mdl_ires_data", bus.ires_data_o, e_i ? bus.mres_data_i : 128'h0);
    chk("mdl_dres_data", bus.dres_data_o, e_d ? bus.mres_data_i : 128'h0);
    seen_i = e_i;
    seen_d = e_d;
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
  endtask

  task automatic clear_inputs();
    bus.ireq_valid_i = 0; bus.ireq_addr_i = '0; bus.ireq_uncached_i = 0;
    bus.dreq_valid_i = 0; bus.dreq_addr_i = '0; bus.dreq_we_i = 0;
    bus.dreq_wdata_i = '0; bus.dreq_uncached_i = 0;
    bus.mreq_ready_i = 0; bus.mres_valid_i = 0; bus.mres_data_i = '0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_inputs();
    tick();
    tick();
    rst_n = 1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  localparam logic [127:0] DATA_A5 = {16{8'hA5}};
  localparam logic [127:0] WDATA_D = 128'h1122_3344_5566_7788_99AA_BBCC_DDEE_FF00;

  initial begin
    bit i_stale, d_stale;
    mdl_reset();
    clear_inputs();
    seen_i = 0; seen_d = 0;
    do_reset();

    // Reset state: every output low.
    at_neg();
    chk("rst_mreq_valid", 128'(bus.mreq_valid_o), 128'h0);
    chk("rst_mreq_addr", 128'(bus.mreq_addr_o), 128'h0);
    chk("rst_mreq_we", 128'(bus.mreq_we_o), 128'h0);
    chk("rst_mreq_wdata", bus.mreq_wdata_o, 128'h0);
    chk("rst_mreq_unc", 128'(bus.mreq_uncached_o), 128'h0);
    chk("rst_ires_valid", 128'(bus.ires_valid_o), 128'h0);
    chk("rst_dres_valid", 128'(bus.dres_valid_o), 128'h0);
    tick();

    // Contention right after reset: I first, then D, then a fresh tie to I.
    bus.ireq_valid_i = 1; bus.ireq_addr_i = 32'h0000_0100;
    bus.dreq_valid_i = 1; bus.dreq_addr_i = 32'h0000_0204;
    tick();
    bus.mreq_ready_i = 1;
    at_neg();
    chk("tie1_valid", 128'(bus.mreq_valid_o), 128'h1);
    chk("tie1_addr_i", 128'(bus.mreq_addr_o), 128'h100);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1; bus.mres_data_i = 128'h1;
    at_neg();
    chk("tie1_ires", 128'(bus.ires_valid_o), 128'h1);
    chk("tie1_dres", 128'(bus.dres_valid_o), 128'h0);
    tick();
    bus.mres_valid_i = 0; bus.ireq_valid_i = 0;
    at_neg();
    chk("tie1_release", 128'(bus.mreq_valid_o), 128'h0);
    tick();
    at_neg();
    chk("tie1_idle", 128'(bus.mreq_valid_o), 128'h0);
    tick();
    bus.mreq_ready_i = 1;
    at_neg();
    chk("tie1_d_valid", 128'(bus.mreq_valid_o), 128'h1);
    chk("tie1_d_addr", 128'(bus.mreq_addr_o), 128'h200);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1; bus.mres_data_i = 128'h2;
    at_neg();
    chk("tie1_d_dres", 128'(bus.dres_valid_o), 128'h1);
    chk("tie1_d_ires", 128'(bus.ires_valid_o), 128'h0);
    tick();
    bus.mres_valid_i = 0;
    bus.ireq_valid_i = 1; bus.ireq_addr_i = 32'h0000_0300;
    bus.dreq_valid_i = 1; bus.dreq_addr_i = 32'h0000_0404;
    tick();
    tick();
    bus.mreq_ready_i = 1;
    at_neg();
    chk("tie2_addr_i", 128'(bus.mreq_addr_o), 128'h300);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1;
    at_neg();
    chk("tie2_ires", 128'(bus.ires_valid_o), 128'h1);
    tick();
    clear_inputs();
    tick();
    tick();
    tick();

    // Instruction only, cached, with a stale level request held into RELEASE.
    bus.ireq_valid_i = 1; bus.ireq_addr_i = 32'h0000_1234;
    tick();
    bus.mreq_ready_i = 1;
    at_neg();
    chk("i_valid", 128'(bus.mreq_valid_o), 128'h1);
    chk("i_addr", 128'(bus.mreq_addr_o), 128'h1230);
    chk("i_we", 128'(bus.mreq_we_o), 128'h0);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1; bus.mres_data_i = DATA_A5;
    at_neg();
    chk("i_ires_valid", 128'(bus.ires_valid_o), 128'h1);
    chk("i_ires_data", bus.ires_data_o, DATA_A5);
    chk("i_dres_valid", 128'(bus.dres_valid_o), 128'h0);
    chk("i_dres_data", bus.dres_data_o, 128'h0);
    tick();
    bus.mres_valid_i = 0;
    at_neg();
    chk("stale_release", 128'(bus.mreq_valid_o), 128'h0);
    tick();
    bus.ireq_valid_i = 0;
    at_neg();
    chk("stale_idle", 128'(bus.mreq_valid_o), 128'h0);
    tick();
    at_neg();
    chk("stale_idle2", 128'(bus.mreq_valid_o), 128'h0);
    tick();

    // Uncached data write stalled three cycles by memory.
    bus.dreq_valid_i = 1; bus.dreq_addr_i = 32'h8000_0006; bus.dreq_we_i = 1;
    bus.dreq_wdata_i = WDATA_D; bus.dreq_uncached_i = 1;
    tick();
    for (int k = 0; k < 3; k++) begin
      at_neg();
      chk("dw_valid", 128'(bus.mreq_valid_o), 128'h1);
      chk("dw_addr", 128'(bus.mreq_addr_o), 128'h8000_0006);
      chk("dw_we", 128'(bus.mreq_we_o), 128'h1);
      chk("dw_wdata", bus.mreq_wdata_o, WDATA_D);
      chk("dw_unc", 128'(bus.mreq_uncached_o), 128'h1);
      tick();
    end
    bus.mreq_ready_i = 1;
    at_neg();
    chk("dw_valid_rdy", 128'(bus.mreq_valid_o), 128'h1);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1; bus.mres_data_i = 128'hBEEF;
    at_neg();
    chk("dw_dres_valid", 128'(bus.dres_valid_o), 128'h1);
    chk("dw_dres_data", bus.dres_data_o, 128'hBEEF);
    tick();
    clear_inputs();
    tick();
    tick();

    // Spurious responses in IDLE and REQ, then async reset while in WAIT.
    bus.mres_valid_i = 1; bus.mres_data_i = 128'hFACE;
    at_neg();
    chk("sp_idle_ires", 128'(bus.ires_valid_o), 128'h0);
    chk("sp_idle_dres", 128'(bus.dres_valid_o), 128'h0);
    chk("sp_idle_data", bus.ires_data_o, 128'h0);
    tick();
    bus.mres_valid_i = 0;
    at_neg();
    chk("sp_idle_stay", 128'(bus.mreq_valid_o), 128'h0);
    bus.ireq_valid_i = 1; bus.ireq_addr_i = 32'h0000_0047; bus.ireq_uncached_i = 1;
    tick();
    bus.mres_valid_i = 1;
    at_neg();
    chk("sp_req_ires", 128'(bus.ires_valid_o), 128'h0);
    chk("sp_req_addr", 128'(bus.mreq_addr_o), 128'h47);
    tick();
    bus.mres_valid_i = 0;
    at_neg();
    chk("sp_req_stay", 128'(bus.mreq_valid_o), 128'h1);
    bus.mreq_ready_i = 1;
    tick();
    bus.mreq_ready_i = 0;
    #2;
    rst_n = 0;
    bus.mres_valid_i = 1;
    #1;
    chk("ar_mreq_valid", 128'(bus.mreq_valid_o), 128'h0);
    chk("ar_mreq_addr", 128'(bus.mreq_addr_o), 128'h0);
    chk("ar_ires_valid", 128'(bus.ires_valid_o), 128'h0);
    chk("ar_ires_data", bus.ires_data_o, 128'h0);
    tick();
    bus.ireq_valid_i = 0;
    rst_n = 1;
    at_neg();
    chk("ar_late_ires", 128'(bus.ires_valid_o), 128'h0);
    tick();
    bus.mres_valid_i = 0;
    at_neg();
    chk("ar_idle", 128'(bus.mreq_valid_o), 128'h0);
    bus.ireq_valid_i = 1; bus.ireq_addr_i = 32'h0000_0500; bus.ireq_uncached_i = 0;
    bus.dreq_valid_i = 1; bus.dreq_addr_i = 32'h0000_0600;
    tick();
    bus.mreq_ready_i = 1;
    at_neg();
    chk("ar_grant_i", 128'(bus.mreq_addr_o), 128'h500);
    tick();
    bus.mreq_ready_i = 0; bus.mres_valid_i = 1;
    tick();
    clear_inputs();
    tick();
    tick();
    tick();
    tick();
    tick();

    // Randomized traffic against the model.
    i_stale = 0; d_stale = 0;
    for (int c = 0; c < 4000; c++) begin
      if (seen_i) begin
        if ($urandom_range(3) == 0) i_stale = 1;
        else bus.ireq_valid_i = 0;
      end else if (i_stale) begin
        bus.ireq_valid_i = 0; i_stale = 0;
      end else if (!bus.ireq_valid_i && $urandom_range(2) == 0) begin
        bus.ireq_valid_i = 1; bus.ireq_addr_i = $urandom;
        bus.ireq_uncached_i = 1'($urandom_range(1));
      end
      if (seen_d) begin
        if ($urandom_range(3) == 0) d_stale = 1;
        else bus.dreq_valid_i = 0;
      end else if (d_stale) begin
        bus.dreq_valid_i = 0; d_stale = 0;
      end else if (!bus.dreq_valid_i && $urandom_range(2) == 0) begin
        bus.dreq_valid_i = 1; bus.dreq_addr_i = $urandom;
        bus.dreq_we_i = 1'($urandom_range(1)); bus.dreq_wdata_i = rnd128();
        bus.dreq_uncached_i = 1'($urandom_range(1));
      end
      bus.mreq_ready_i = ($urandom_range(2) == 0);
      bus.mres_valid_i = ($urandom_range(2) == 0);
      bus.mres_data_i  = rnd128();
      tick();
    end
    clear_inputs();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
